// File: rtl/mac_acc_block_pkg.sv
// Shared encodings for the MAC accumulation stage: precision modes, FSM states
// and the active-precision width helper.
package mac_acc_block_pkg;

    typedef enum logic [1:0] {
        MAC_SINGLE = 2'd0,
        MAC_DUAL   = 2'd1,
        MAC_QUAD   = 2'd2,
        MAC_RSVD   = 2'd3
    } mac_mode_e;

    typedef enum logic [1:0] {
        MAC_ACC_IDLE  = 2'd0,
        MAC_ACC_ACCUM = 2'd1,
        MAC_ACC_HOLD  = 2'd2
    } acc_state_e;

    // Number of low product bits that survive masking; reserved mode keeps none.
    function automatic int mode_width(mac_mode_e mode, int min_width);
        case (mode)
            MAC_SINGLE: return 2 * min_width;
            MAC_DUAL:   return 3 * min_width;
            MAC_QUAD:   return 5 * min_width;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/mac_acc_block_if.sv
// Product-in / frame-result-out handshake bundle of the MAC accumulation stage.
interface mac_acc_block_if #(
    parameter int INT_WIDTH = 40,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [INT_WIDTH-1:0] in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/mac_acc_block_add.sv
// Masked accumulate: zero-extends the precision-masked product and adds it to acc.
// Define MAC_ACC_SAT_EN to clamp the sum to all-ones on carry-out instead of wrapping.
module mac_acc_block_add
    import mac_acc_block_pkg::*;
#(
    parameter int MIN_WIDTH = 8,
    parameter int INT_WIDTH = 5 * MIN_WIDTH,
    parameter int ACC_WIDTH = INT_WIDTH + 8
) (
    input  mac_mode_e            mode,
    input  logic [INT_WIDTH-1:0] product,
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry
);
    int                   active_bits;
    logic [INT_WIDTH-1:0] masked;
    logic [ACC_WIDTH:0]   wide;

    always_comb begin
        active_bits = mode_width(mode, MIN_WIDTH);
        masked      = '0;
        for (int i = 0; i < INT_WIDTH; i++) begin
            masked[i] = product[i] && (i < active_bits);
        end
        wide  = {1'b0, acc} + (ACC_WIDTH + 1)'(masked);
        carry = wide[ACC_WIDTH];
`ifdef MAC_ACC_SAT_EN
        // Once clamped, any further non-zero addend carries again, so it stays clamped.
        sum = carry ? '1 : wide[ACC_WIDTH-1:0];
`else
        sum = wide[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/mac_acc_block.sv
// Frame accumulator behind the MAC multipliers with a 1-entry result register.
// Build option MAC_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mac_acc_block
    import mac_acc_block_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = MAC_INT_WIDTH + 8,
    parameter int MAX_BEATS      = 16,
    parameter int CNT_WIDTH      = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    mac_acc_block_if.slave            bus
);
    acc_state_e               state_q, state_d;
    logic [MAC_ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]     count_q, count_d;
    logic                     ovf_q, ovf_d;
    mac_mode_e                cfg_q, cfg_d;
    logic [MAC_ACC_WIDTH-1:0] res_data_q, res_data_d;
    logic [CNT_WIDTH-1:0]     res_count_q, res_count_d;
    logic                     res_ovf_q, res_ovf_d;

    logic                     frame_start;
    mac_mode_e                add_mode;
    logic                     in_ready;
    logic                     accept;
    logic [CNT_WIDTH-1:0]     next_count;
    logic                     closing;
    logic [MAC_ACC_WIDTH-1:0] sum;
    logic                     carry;
    logic                     unused_cfg;

    assign unused_cfg = ^cfg[MAC_CONF_WIDTH-1:2];

    // Any beat seen outside ACCUM opens a new frame and uses the live cfg.
    assign frame_start = (state_q != MAC_ACC_ACCUM);
    assign add_mode    = frame_start ? mac_mode_e'(cfg[1:0]) : cfg_q;
    assign in_ready    = !rst && en && ((state_q != MAC_ACC_HOLD) || bus.out_ready);
    assign accept      = bus.in_valid && in_ready;
    assign next_count  = count_q + CNT_WIDTH'(1);
    assign closing     = bus.in_last || (next_count == CNT_WIDTH'(MAX_BEATS));

    mac_acc_block_add #(
        .MIN_WIDTH (MAC_MIN_WIDTH),
        .INT_WIDTH (MAC_INT_WIDTH),
        .ACC_WIDTH (MAC_ACC_WIDTH)
    ) u_add (
        .mode    (add_mode),
        .product (bus.in_data),
        .acc     (acc_q),
        .sum     (sum),
        .carry   (carry)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latches).
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        cfg_d       = cfg_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;

        if (accept) begin
            if (frame_start) begin
                cfg_d = mac_mode_e'(cfg[1:0]);
            end
            if (closing) begin
                res_data_d  = sum;
                res_count_d = next_count;
                res_ovf_d   = ovf_q || carry;
                acc_d       = '0;
                count_d     = '0;
                ovf_d       = 1'b0;
                state_d     = MAC_ACC_HOLD;
            end else begin
                acc_d   = sum;
                count_d = next_count;
                ovf_d   = ovf_q || carry;
                state_d = MAC_ACC_ACCUM;
            end
        end else if ((state_q == MAC_ACC_HOLD) && en && bus.out_ready) begin
            state_d = MAC_ACC_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MAC_ACC_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cfg_q       <= MAC_SINGLE;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cfg_q       <= cfg_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == MAC_ACC_HOLD);
    assign bus.out_data  = res_data_q;
    assign bus.out_count = res_count_q;
    assign bus.out_ovf   = res_ovf_q;

endmodule
